// File: rtl/alu_pkg.sv
// alu_pkg: ALU opcodes and datapath widths shared by the execute stage
package alu_pkg;
  localparam int DW = 32;
  localparam int RN = 5;
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_ADDU = 4'b1001;
  localparam logic [3:0] ALU_SUBU = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
endpackage

// File: rtl/ex_stage_if.sv
// ex_stage_if: ID/EX operands, MEM/WB bypasses, pipeline control and EX/MEM outputs
interface ex_stage_if;
  import alu_pkg::*;
  logic          id_valid;
  logic [3:0]    id_alu_ctr;
  logic          id_shift;
  logic          id_jr;
  logic          id_alu_src;
  logic [RN-1:0] id_rs_num;
  logic [RN-1:0] id_rt_num;
  logic [RN-1:0] id_dst_num;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [DW-1:0] id_imm;
  logic [4:0]    id_shamt;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          mem_fwd_we;
  logic [RN-1:0] mem_fwd_num;
  logic [DW-1:0] mem_fwd_val;
  logic          wb_fwd_we;
  logic [RN-1:0] wb_fwd_num;
  logic [DW-1:0] wb_fwd_val;
  logic          stall;
  logic          flush;
  logic          jr_taken;
  logic [DW-1:0] jr_target;
  logic          ex_valid;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic [DW-1:0] ex_result;
  logic [DW-1:0] ex_store_data;
  logic [RN-1:0] ex_dst_num;
  logic          ex_zero;
  logic          ex_ovf;
  modport master (
    output id_valid, id_alu_ctr, id_shift, id_jr, id_alu_src, id_rs_num, id_rt_num, id_dst_num,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_reg_write, id_mem_read, id_mem_write,
           mem_fwd_we, mem_fwd_num, mem_fwd_val, wb_fwd_we, wb_fwd_num, wb_fwd_val, stall, flush,
    input  jr_taken, jr_target, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_result,
           ex_store_data, ex_dst_num, ex_zero, ex_ovf
  );
  modport slave (
    input  id_valid, id_alu_ctr, id_shift, id_jr, id_alu_src, id_rs_num, id_rt_num, id_dst_num,
           id_rs_val, id_rt_val, id_imm, id_shamt, id_reg_write, id_mem_read, id_mem_write,
           mem_fwd_we, mem_fwd_num, mem_fwd_val, wb_fwd_we, wb_fwd_num, wb_fwd_val, stall, flush,
    output jr_taken, jr_target, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_result,
           ex_store_data, ex_dst_num, ex_zero, ex_ovf
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational MIPS ALU, shifts act on b, ovf only for signed add/sub
module alu_core
  import alu_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [4:0]    shamt_sel,
  input  logic [3:0]    ctr,
  output logic [DW-1:0] result,
  output logic          ovf
);
  logic [DW-1:0] sum, diff;
  assign sum  = a + b;
  assign diff = a - b;
  assign ovf  = ctr == ALU_ADD ? (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]) :
                ctr == ALU_SUB ? (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]) : 1'b0;
  // opcode decode; unlisted codes give 0
  always_comb begin
    result = '0;
    case (ctr)
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_ADD,
      ALU_ADDU: result = sum;
      ALU_SUB,
      ALU_SUBU: result = diff;
      ALU_SLL:  result = b << shamt_sel;
      ALU_SRL:  result = b >> shamt_sel;
      ALU_SRA:  result = $signed(b) >>> shamt_sel;
      ALU_SLT:  result = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: result = {{(DW-1){1'b0}}, a < b};
      ALU_LUI:  result = b << 16;
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
      default:  result = '0;
    endcase
  end
endmodule

// File: rtl/ex_stage.sv
// ex_stage: forwarding, ALU and EX/MEM register; OVERFLOW_TRAP_EN suppresses writeback on add/sub overflow
module ex_stage
  import alu_pkg::*;
(
  input logic       clk,
  input logic       reset,
  ex_stage_if.slave io
);
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  logic [DW-1:0] a, rt_fwd, b, result;
  logic          ovf, trap;
  assign a = io.id_rs_num == '0 ? '0 :
             io.mem_fwd_we && io.mem_fwd_num == io.id_rs_num ? io.mem_fwd_val :
             io.wb_fwd_we && io.wb_fwd_num == io.id_rs_num ? io.wb_fwd_val : io.id_rs_val;
  assign rt_fwd = io.id_rt_num == '0 ? '0 :
                  io.mem_fwd_we && io.mem_fwd_num == io.id_rt_num ? io.mem_fwd_val :
                  io.wb_fwd_we && io.wb_fwd_num == io.id_rt_num ? io.wb_fwd_val : io.id_rt_val;
  assign b = io.id_alu_src ? io.id_imm : rt_fwd;
  assign io.jr_taken  = io.id_valid & io.id_jr;
  assign io.jr_target = a;
  assign trap = TRAP & ovf;
  alu_core u_alu (
    .a(a),
    .b(b),
    .shamt_sel(io.id_shift ? io.id_shamt : a[4:0]),
    .ctr(io.id_alu_ctr),
    .result(result),
    .ovf(ovf)
  );
  // EX/MEM register: flush clears control, stall holds, otherwise capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io.ex_valid      <= 1'b0;
      io.ex_reg_write  <= 1'b0;
      io.ex_mem_read   <= 1'b0;
      io.ex_mem_write  <= 1'b0;
      io.ex_result     <= '0;
      io.ex_store_data <= '0;
      io.ex_dst_num    <= '0;
      io.ex_zero       <= 1'b0;
      io.ex_ovf        <= 1'b0;
    end else if (io.flush) begin
      io.ex_valid      <= 1'b0;
      io.ex_reg_write  <= 1'b0;
      io.ex_mem_read   <= 1'b0;
      io.ex_mem_write  <= 1'b0;
      io.ex_ovf        <= 1'b0;
    end else if (!io.stall) begin
      io.ex_valid      <= io.id_valid;
      io.ex_reg_write  <= io.id_valid & io.id_reg_write & ~io.id_jr & ~trap;
      io.ex_mem_read   <= io.id_valid & io.id_mem_read;
      io.ex_mem_write  <= io.id_valid & io.id_mem_write;
      io.ex_result     <= result;
      io.ex_store_data <= rt_fwd;
      io.ex_dst_num    <= io.id_dst_num;
      io.ex_zero       <= result == '0;
      io.ex_ovf        <= io.id_valid & trap;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors for forwarding, ALU ops, overflow, stall/flush and async reset
module tb_ex_stage;
  import alu_pkg::*;
`ifdef OVERFLOW_TRAP_EN
  localparam logic OVF_EXP = 1'b1;
  localparam logic OVF_RW_EXP = 1'b0;
`else
  localparam logic OVF_EXP = 1'b0;
  localparam logic OVF_RW_EXP = 1'b1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  ex_stage_if io ();
  ex_stage dut (.clk(clk), .reset(reset), .io(io));
  always #5 clk = ~clk;

  task automatic idle();
    io.id_valid = 0; io.id_alu_ctr = 0; io.id_shift = 0; io.id_jr = 0; io.id_alu_src = 0;
    io.id_rs_num = 0; io.id_rt_num = 0; io.id_dst_num = 0; io.id_rs_val = 0; io.id_rt_val = 0;
    io.id_imm = 0; io.id_shamt = 0; io.id_reg_write = 0; io.id_mem_read = 0; io.id_mem_write = 0;
    io.mem_fwd_we = 0; io.mem_fwd_num = 0; io.mem_fwd_val = 0;
    io.wb_fwd_we = 0; io.wb_fwd_num = 0; io.wb_fwd_val = 0;
    io.stall = 0; io.flush = 0;
  endtask

  task automatic op(input logic [3:0] ctr, input logic [4:0] rs, input logic [31:0] rsv,
                    input logic [4:0] rt, input logic [31:0] rtv);
    idle();
    io.id_valid = 1; io.id_reg_write = 1; io.id_dst_num = 5'd3; io.id_alu_ctr = ctr;
    io.id_rs_num = rs; io.id_rs_val = rsv; io.id_rt_num = rt; io.id_rt_val = rtv;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.ex_zero, io.ex_ovf} !== 6'b0) begin
      miscompares++; $display("FAIL reset_ctrl got %b exp 000000",
        {io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.ex_zero, io.ex_ovf});
    end
    vectors++;
    if ({io.ex_result, io.ex_store_data, io.ex_dst_num} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h %h %h exp 0", io.ex_result, io.ex_store_data, io.ex_dst_num);
    end
    reset = 0;
  endtask

  task automatic test_add();
    op(ALU_ADD, 5'd5, 32'd7, 5'd6, 32'd8);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd15) begin miscompares++; $display("FAIL add_result got %h exp %h", io.ex_result, 32'd15); end
    vectors++;
    if ({io.ex_valid, io.ex_reg_write, io.ex_zero, io.ex_ovf} !== 4'b1100) begin
      miscompares++; $display("FAIL add_flags got %b exp 1100", {io.ex_valid, io.ex_reg_write, io.ex_zero, io.ex_ovf});
    end
    vectors++;
    if (io.ex_dst_num !== 5'd3 || io.ex_store_data !== 32'd8) begin
      miscompares++; $display("FAIL add_dst_store got %0d %h exp 3 8", io.ex_dst_num, io.ex_store_data);
    end
    op(ALU_ADD, 5'd5, 32'd7, 5'd6, 32'd8);
    io.id_valid = 0; io.id_mem_write = 1;
    @(negedge clk);
    vectors++;
    if ({io.ex_valid, io.ex_reg_write, io.ex_mem_write} !== 3'b000) begin
      miscompares++; $display("FAIL bubble_ctrl got %b exp 000", {io.ex_valid, io.ex_reg_write, io.ex_mem_write});
    end
  endtask

  task automatic test_forwarding();
    op(ALU_OR, 5'd5, 32'd1, 5'd0, 32'd123);
    io.mem_fwd_we = 1; io.mem_fwd_num = 5'd5; io.mem_fwd_val = 32'd100;
    io.wb_fwd_we = 1; io.wb_fwd_num = 5'd5; io.wb_fwd_val = 32'd50;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd100) begin miscompares++; $display("FAIL fwd_mem_prio got %0d exp 100", io.ex_result); end
    vectors++;
    if (io.ex_store_data !== 32'd0) begin miscompares++; $display("FAIL fwd_r0_store got %0d exp 0", io.ex_store_data); end
    io.mem_fwd_we = 0;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd50) begin miscompares++; $display("FAIL fwd_wb got %0d exp 50", io.ex_result); end
    op(ALU_ADD, 5'd0, 32'd99, 5'd7, 32'd4);
    io.mem_fwd_we = 1; io.mem_fwd_num = 5'd0; io.mem_fwd_val = 32'd77;
    io.wb_fwd_we = 1; io.wb_fwd_num = 5'd7; io.wb_fwd_val = 32'd9;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd9) begin miscompares++; $display("FAIL fwd_r0_rt_wb got %0d exp 9", io.ex_result); end
    op(ALU_ADD, 5'd5, 32'd1, 5'd0, 32'd0);
    io.id_jr = 1;
    io.mem_fwd_we = 1; io.mem_fwd_num = 5'd5; io.mem_fwd_val = 32'h0040_0100;
    io.stall = 1;
    #1;
    vectors++;
    if (io.jr_taken !== 1'b1 || io.jr_target !== 32'h0040_0100) begin
      miscompares++; $display("FAIL jr_comb got %b %h exp 1 00400100", io.jr_taken, io.jr_target);
    end
    io.stall = 0;
    @(negedge clk);
    vectors++;
    if (io.ex_reg_write !== 1'b0 || io.ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL jr_regwrite got rw=%b v=%b exp rw=0 v=1", io.ex_reg_write, io.ex_valid);
    end
    io.id_valid = 0;
    #1;
    vectors++;
    if (io.jr_taken !== 1'b0) begin miscompares++; $display("FAIL jr_gate got %b exp 0", io.jr_taken); end
  endtask

  task automatic test_alu_ops();
    op(ALU_SRA, 5'd9, 32'd0, 5'd6, 32'h8000_0000);
    io.id_shift = 1; io.id_shamt = 5'd4;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'hF800_0000) begin miscompares++; $display("FAIL sra got %h exp f8000000", io.ex_result); end
    op(ALU_SRL, 5'd9, 32'd4, 5'd6, 32'h8000_0000);
    io.id_shamt = 5'd20;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h0800_0000) begin miscompares++; $display("FAIL srl got %h exp 08000000", io.ex_result); end
    op(ALU_SLL, 5'd9, 32'd0, 5'd6, 32'h0000_0003);
    io.id_shift = 1; io.id_shamt = 5'd31;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h8000_0000) begin miscompares++; $display("FAIL sll got %h exp 80000000", io.ex_result); end
    op(ALU_LUI, 5'd0, 32'd0, 5'd0, 32'd0);
    io.id_alu_src = 1; io.id_imm = 32'h0000_1234;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h1234_0000) begin miscompares++; $display("FAIL lui got %h exp 12340000", io.ex_result); end
    op(ALU_SUB, 5'd1, 32'd5, 5'd2, 32'd7);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'hFFFF_FFFE || io.ex_ovf !== 1'b0) begin
      miscompares++; $display("FAIL sub got %h ovf=%b exp fffffffe ovf=0", io.ex_result, io.ex_ovf);
    end
    op(ALU_SLT, 5'd1, 32'hFFFF_FFFF, 5'd2, 32'd1);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd1) begin miscompares++; $display("FAIL slt got %h exp 1", io.ex_result); end
    io.id_alu_ctr = ALU_SLTU;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd0 || io.ex_zero !== 1'b1) begin
      miscompares++; $display("FAIL sltu got %h z=%b exp 0 z=1", io.ex_result, io.ex_zero);
    end
    op(ALU_NOR, 5'd1, 32'hF0F0_0000, 5'd2, 32'h0000_00FF);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h0F0F_FF00) begin miscompares++; $display("FAIL nor got %h exp 0f0fff00", io.ex_result); end
    io.id_alu_ctr = ALU_XOR;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'hF0F0_00FF) begin miscompares++; $display("FAIL xor got %h exp f0f000ff", io.ex_result); end
    io.id_alu_ctr = ALU_AND;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd0) begin miscompares++; $display("FAIL and got %h exp 0", io.ex_result); end
    op(4'b0101, 5'd1, 32'd3, 5'd2, 32'd4);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd0 || io.ex_zero !== 1'b1) begin
      miscompares++; $display("FAIL undef_op got %h z=%b exp 0 z=1", io.ex_result, io.ex_zero);
    end
  endtask

  task automatic test_overflow();
    op(ALU_ADD, 5'd1, 32'h7FFF_FFFF, 5'd2, 32'd1);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h8000_0000 || io.ex_ovf !== OVF_EXP || io.ex_reg_write !== OVF_RW_EXP) begin
      miscompares++; $display("FAIL add_ovf got %h ovf=%b rw=%b exp 80000000 ovf=%b rw=%b",
        io.ex_result, io.ex_ovf, io.ex_reg_write, OVF_EXP, OVF_RW_EXP);
    end
    io.id_alu_ctr = ALU_ADDU;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h8000_0000 || io.ex_ovf !== 1'b0 || io.ex_reg_write !== 1'b1) begin
      miscompares++; $display("FAIL addu_noovf got %h ovf=%b rw=%b exp 80000000 ovf=0 rw=1",
        io.ex_result, io.ex_ovf, io.ex_reg_write);
    end
    op(ALU_SUB, 5'd1, 32'h8000_0000, 5'd2, 32'd1);
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'h7FFF_FFFF || io.ex_ovf !== OVF_EXP || io.ex_reg_write !== OVF_RW_EXP) begin
      miscompares++; $display("FAIL sub_ovf got %h ovf=%b rw=%b exp 7fffffff ovf=%b rw=%b",
        io.ex_result, io.ex_ovf, io.ex_reg_write, OVF_EXP, OVF_RW_EXP);
    end
    io.id_alu_ctr = ALU_SUBU;
    @(negedge clk);
    vectors++;
    if (io.ex_ovf !== 1'b0 || io.ex_reg_write !== 1'b1) begin
      miscompares++; $display("FAIL subu_noovf got ovf=%b rw=%b exp ovf=0 rw=1", io.ex_ovf, io.ex_reg_write);
    end
  endtask

  task automatic test_stall_flush();
    op(ALU_ADD, 5'd5, 32'd7, 5'd6, 32'd8);
    io.id_mem_read = 1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      io.stall = 1; io.id_alu_ctr = ALU_SUB; io.id_rs_val = 32'd100 + i; io.id_dst_num = 5'd9; io.id_valid = 0;
      @(negedge clk);
      vectors++;
      if (io.ex_result !== 32'd15 || io.ex_valid !== 1'b1 || io.ex_mem_read !== 1'b1 || io.ex_dst_num !== 5'd3) begin
        miscompares++; $display("FAIL stall_hold%0d got %h v=%b mr=%b dst=%0d exp 0000000f v=1 mr=1 dst=3",
          i, io.ex_result, io.ex_valid, io.ex_mem_read, io.ex_dst_num);
      end
    end
    io.flush = 1; io.id_valid = 1;
    @(negedge clk);
    vectors++;
    if ({io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.ex_ovf} !== 5'b0) begin
      miscompares++; $display("FAIL flush_stall got %b exp 00000",
        {io.ex_valid, io.ex_reg_write, io.ex_mem_read, io.ex_mem_write, io.ex_ovf});
    end
  endtask

  task automatic test_async_reset();
    op(ALU_ADD, 5'd5, 32'd7, 5'd6, 32'd8);
    @(negedge clk);
    vectors++;
    if (io.ex_valid !== 1'b1) begin miscompares++; $display("FAIL areset_pre got %b exp 1", io.ex_valid); end
    @(posedge clk);
    #2 reset = 1;
    #1;
    vectors++;
    if ({io.ex_valid, io.ex_reg_write, io.ex_result, io.ex_dst_num, io.ex_store_data} !== '0) begin
      miscompares++; $display("FAIL areset_now got v=%b rw=%b r=%h d=%0d s=%h exp all 0",
        io.ex_valid, io.ex_reg_write, io.ex_result, io.ex_dst_num, io.ex_store_data);
    end
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    vectors++;
    if (io.ex_result !== 32'd15 || io.ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_resume got %h v=%b exp 0000000f v=1", io.ex_result, io.ex_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_forwarding();
    test_alu_ops();
    test_overflow();
    test_stall_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
